// File: rtl/vstore_data_translator_pkg.sv
// Shared types and constants for the vector store data translator and its lane aligner.
package vstore_data_translator_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned BE_W    = DATA_W / 8;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned WADDR_W = ADDR_W - 2;

    // Access size encoding shared with the load translator; any 1x code is a word.
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } wc_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [BE_W-1:0]   be;
    } lane_word_t;

    // Byte lanes selected by be take the new data; the rest keep the old data.
    function automatic logic [DATA_W-1:0] merge_lanes(
        input logic [DATA_W-1:0] old_data,
        input logic [DATA_W-1:0] new_data,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] res;
        res = old_data;
        for (int i = 0; i < int'(BE_W); i++) begin
            if (be[i]) begin
                res[i*8 +: 8] = new_data[i*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/vstore_lane_align.sv
// Places right-justified store data into big-endian byte lanes and builds byte enables.
module vstore_lane_align
    import vstore_data_translator_pkg::*;
(
    input  logic [1:0]        addr_lo,
    input  logic [1:0]        size,
    input  logic [DATA_W-1:0] data,
    output lane_word_t        aligned_c
);

    always_comb begin
        aligned_c.data = data;
        aligned_c.be   = '1;
        if ((size & SIZE_WORD) != 2'b00) begin
            aligned_c.data = data;
            aligned_c.be   = 4'b1111;
        end else if (size == SIZE_HALF) begin
            aligned_c.data = {2{data[15:0]}};
            aligned_c.be   = addr_lo[1] ? 4'b0011 : 4'b1100;
        end else if (size == SIZE_BYTE) begin
            // Byte address 0 lives in the most significant lane.
            aligned_c.data = {4{data[7:0]}};
            aligned_c.be   = 4'b1000 >> addr_lo;
        end
    end

endmodule

// File: rtl/vstore_data_translator.sv
// Vector store data translator: lane alignment plus a one-entry write-combining buffer
// that merges sub-word stores to the same word before writing memory.
module vstore_data_translator
    import vstore_data_translator_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 8,
    parameter int unsigned TCW     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               st_valid,
    output logic               st_ready,
    input  logic [ADDR_W-1:0]  st_address,
    input  logic [1:0]         st_size,
    input  logic [WIDTH-1:0]   st_data,
    input  logic               st_flush,
    output logic               mem_valid,
    input  logic               mem_ready,
    output logic [WADDR_W-1:0] mem_address,
    output logic [WIDTH-1:0]   mem_writedata,
    output logic [BE_W-1:0]    mem_byteen,
    output logic               busy
);

    wc_state_e           state_q, state_d;
    logic [WADDR_W-1:0]  buf_addr_q, buf_addr_d;
    logic [DATA_W-1:0]   buf_data_q, buf_data_d;
    logic [BE_W-1:0]     buf_be_q, buf_be_d;
    logic [TCW-1:0]      cnt_q, cnt_d;
    logic                mem_valid_q;

    lane_word_t          aligned;
    logic [WADDR_W-1:0]  word_addr;
    logic                same_word;
    logic [BE_W-1:0]     merged_be;
    logic [DATA_W-1:0]   merged_data;
    logic                timed_out;

    vstore_lane_align u_lane_align (
        .addr_lo   (st_address[1:0]),
        .size      (st_size),
        .data      (st_data),
        .aligned_c (aligned)
    );

    assign word_addr   = st_address[ADDR_W-1:2];
    assign same_word   = (word_addr == buf_addr_q);
    assign merged_be   = buf_be_q | aligned.be;
    assign merged_data = merge_lanes(buf_data_q, aligned.data, aligned.be);
    assign timed_out   = (cnt_q == TCW'(TIMEOUT - 1));

    // Next-state, buffer update and request-side handshake.
    always_comb begin
        state_d    = state_q;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        buf_be_d   = buf_be_q;
        cnt_d      = '0;
        st_ready   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                st_ready = 1'b1;
                if (st_valid) begin
                    buf_addr_d = word_addr;
                    buf_data_d = aligned.data;
                    buf_be_d   = aligned.be;
                    state_d    = (aligned.be == 4'b1111) ? ST_DRAIN : ST_HOLD;
                end
            end
            ST_HOLD: begin
                // A store to another word, or a flush, stalls the request until drained.
                st_ready = !(st_valid && !same_word) && !st_flush;
                if (st_valid && st_ready) begin
                    buf_data_d = merged_data;
                    buf_be_d   = merged_be;
                    state_d    = (merged_be == 4'b1111) ? ST_DRAIN : ST_HOLD;
                end else if (st_flush || st_valid || timed_out) begin
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d = TCW'(cnt_q + 1'b1);
                end
            end
            ST_DRAIN: begin
                if (mem_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and buffer registers; reset discards any buffered word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            buf_be_q    <= '0;
            cnt_q       <= '0;
            mem_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            buf_be_q    <= buf_be_d;
            cnt_q       <= cnt_d;
            mem_valid_q <= (state_d == ST_DRAIN);
        end
    end

    assign mem_valid     = mem_valid_q;
    assign mem_address   = buf_addr_q;
    assign mem_writedata = buf_data_q;
    assign mem_byteen    = buf_be_q;
    assign busy          = (state_q != ST_IDLE);

endmodule
